dma: RTL and testbench

Bus-master DMA engine for the JTAG interface. It moves a block of 32-bit words between the local ping-pong buffer and the system bus, in bursts. Transfers are launched by the IP core. The block arbitrates for the bus with a request/grant pair and drives or receives the bus address/data phases.

---
 rtl/dma.sv | 187 ++++++++++++++++++
 tb/tb_dma.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma.sv
// Bus-master DMA between the ping-pong buffer and the system bus, in bursts.
// Define DMA_STATE_DEBUG_EN to expose the FSM state on s_dma_cur_state.
module dma (
  input  logic        clock,
  input  logic        n_reset,
  input  logic        ipcore_launch_write,
  input  logic        ipcore_launch_read,
  input  logic [3:0]  ipcore_byte_enable,
  input  logic [31:0] ipcore_address,
  input  logic [7:0]  ipcore_burst_size,
  input  logic [7:0]  ipcore_block_sizeIN,
  output logic        ipcore_dma_busy,
  output logic [7:0]  ipcore_block_sizeOUT,
  output logic [8:0]  pp_address,
  output logic [31:0] pp_dataIn,
  output logic        pp_writeEnable,
  input  logic [31:0] pp_dataOut,
  input  logic [31:0] address_dataIN,
  input  logic        end_transactionIN,
  input  logic        data_validIN,
  input  logic        busyIN,
  input  logic        bus_errorIN,
  output logic [31:0] address_dataOUT,
  output logic [3:0]  byte_enableOUT,
  output logic [7:0]  busrt_sizeOUT,
  output logic        read_n_writeOUT,
  output logic        begin_transactionOUT,
  output logic        end_transactionOUT,
  output logic        data_validOUT,
  output logic        busyOUT,
  output logic        requestTransaction,
  input  logic        transactionGranted,
  output logic [3:0]  s_dma_cur_state
);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_REQUEST    = 4'd1,
    S_BEGIN      = 4'd2,
    S_WRITE_DATA = 4'd3,
    S_END_WRITE  = 4'd4,
    S_READ_DATA  = 4'd5,
    S_NEXT       = 4'd6
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [7:0]  burst_q, burst_d;
  logic [7:0]  remain_q, remain_d;
  logic        rd_q, rd_d;
  logic [7:0]  word_idx_q, word_idx_d;
  logic [7:0]  done_q, done_d;

  logic [8:0]  burst_p1;
  logic [7:0]  words;
  logic [7:0]  in_burst;

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      be_q       <= '0;
      burst_q    <= '0;
      remain_q   <= '0;
      rd_q       <= 1'b0;
      word_idx_q <= '0;
      done_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      burst_q    <= burst_d;
      remain_q   <= remain_d;
      rd_q       <= rd_d;
      word_idx_q <= word_idx_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    be_d       = be_q;
    burst_d    = burst_q;
    remain_d   = remain_q;
    rd_d       = rd_q;
    word_idx_d = word_idx_q;
    done_d     = done_q;

    address_dataOUT      = '0;
    byte_enableOUT       = '0;
    busrt_sizeOUT        = '0;
    read_n_writeOUT      = 1'b0;
    begin_transactionOUT = 1'b0;
    end_transactionOUT   = 1'b0;
    data_validOUT        = 1'b0;
    busyOUT              = 1'b0;
    requestTransaction   = 1'b0;
    pp_dataIn            = '0;
    pp_writeEnable       = 1'b0;

    burst_p1 = {1'b0, burst_q} + 9'd1;
    words    = (burst_p1 > {1'b0, remain_q}) ? remain_q : burst_p1[7:0];
    in_burst = word_idx_q - done_q;

    unique case (state_q)
      S_IDLE: begin
        if (ipcore_launch_write || ipcore_launch_read) begin
          addr_d     = ipcore_address;
          be_d       = ipcore_byte_enable;
          burst_d    = ipcore_burst_size;
          remain_d   = ipcore_block_sizeIN;
          rd_d       = !ipcore_launch_write;
          word_idx_d = '0;
          done_d     = '0;
          if (ipcore_block_sizeIN != 8'd0)
            state_d = S_REQUEST;
        end
      end
      S_REQUEST: begin
        requestTransaction = 1'b1;
        if (transactionGranted)
          state_d = S_BEGIN;
      end
      S_BEGIN: begin
        begin_transactionOUT = 1'b1;
        address_dataOUT      = addr_q;
        byte_enableOUT       = be_q;
        busrt_sizeOUT        = words - 8'd1;
        read_n_writeOUT      = rd_q;
        state_d = rd_q ? S_READ_DATA : S_WRITE_DATA;
      end
      S_WRITE_DATA: begin
        data_validOUT   = 1'b1;
        address_dataOUT = pp_dataOut;
        if (!busyIN) begin
          word_idx_d = word_idx_q + 8'd1;
          if (in_burst + 8'd1 == words)
            state_d = S_END_WRITE;
        end
      end
      S_END_WRITE: begin
        end_transactionOUT = 1'b1;
        state_d = S_NEXT;
      end
      S_READ_DATA: begin
        if (data_validIN && (in_burst < words)) begin
          pp_writeEnable = 1'b1;
          pp_dataIn      = address_dataIN;
          word_idx_d     = word_idx_q + 8'd1;
        end
        if (end_transactionIN)
          state_d = S_NEXT;
      end
      S_NEXT: begin
        addr_d     = addr_q + {22'd0, words, 2'b00};
        remain_d   = remain_q - words;
        done_d     = done_q + words;
        word_idx_d = done_q + words;
        state_d    = (remain_q == words) ? S_IDLE : S_REQUEST;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort keeps only the words already moved in the current burst
    if (bus_errorIN && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      word_idx_d = word_idx_q;
      done_d     = word_idx_q;
    end
  end

  // Write path looks one word ahead so buffer data meets the valid cycle
  assign pp_address = {1'b0,
    ((state_q == S_READ_DATA) || (state_q == S_IDLE)) ? word_idx_q : word_idx_d};

  assign ipcore_dma_busy      = (state_q != S_IDLE);
  assign ipcore_block_sizeOUT = done_q;

`ifdef DMA_STATE_DEBUG_EN
  assign s_dma_cur_state = state_q;
`else
  assign s_dma_cur_state = 4'h0;
`endif

endmodule

// File: tb/tb_dma.sv
// Scoreboard bench for dma: expected bus begins, write words and buffer
// writes are queued by the stimulus and consumed by a negedge monitor.
module tb_dma;
  logic        clock = 1'b0;
  logic        n_reset;
  logic        ipcore_launch_write, ipcore_launch_read;
  logic [3:0]  ipcore_byte_enable;
  logic [31:0] ipcore_address;
  logic [7:0]  ipcore_burst_size, ipcore_block_sizeIN;
  logic        ipcore_dma_busy;
  logic [7:0]  ipcore_block_sizeOUT;
  logic [8:0]  pp_address;
  logic [31:0] pp_dataIn;
  logic        pp_writeEnable;
  logic [31:0] pp_dataOut;
  logic [31:0] address_dataIN;
  logic        end_transactionIN, data_validIN, busyIN, bus_errorIN;
  logic [31:0] address_dataOUT;
  logic [3:0]  byte_enableOUT;
  logic [7:0]  busrt_sizeOUT;
  logic        read_n_writeOUT, begin_transactionOUT, end_transactionOUT;
  logic        data_validOUT, busyOUT, requestTransaction, transactionGranted;
  logic [3:0]  s_dma_cur_state;

  dma dut (
    .clock(clock), .n_reset(n_reset),
    .ipcore_launch_write(ipcore_launch_write),
    .ipcore_launch_read(ipcore_launch_read),
    .ipcore_byte_enable(ipcore_byte_enable),
    .ipcore_address(ipcore_address),
    .ipcore_burst_size(ipcore_burst_size),
    .ipcore_block_sizeIN(ipcore_block_sizeIN),
    .ipcore_dma_busy(ipcore_dma_busy),
    .ipcore_block_sizeOUT(ipcore_block_sizeOUT),
    .pp_address(pp_address), .pp_dataIn(pp_dataIn),
    .pp_writeEnable(pp_writeEnable), .pp_dataOut(pp_dataOut),
    .address_dataIN(address_dataIN),
    .end_transactionIN(end_transactionIN),
    .data_validIN(data_validIN), .busyIN(busyIN),
    .bus_errorIN(bus_errorIN),
    .address_dataOUT(address_dataOUT),
    .byte_enableOUT(byte_enableOUT),
    .busrt_sizeOUT(busrt_sizeOUT),
    .read_n_writeOUT(read_n_writeOUT),
    .begin_transactionOUT(begin_transactionOUT),
    .end_transactionOUT(end_transactionOUT),
    .data_validOUT(data_validOUT), .busyOUT(busyOUT),
    .requestTransaction(requestTransaction),
    .transactionGranted(transactionGranted),
    .s_dma_cur_state(s_dma_cur_state)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  bs;
    logic        rnw;
    logic [3:0]  be;
  } beg_t;

  beg_t        exp_beg[$];
  logic [31:0] exp_w[$];
  logic [8:0]  exp_pa[$];
  logic [31:0] exp_pd[$];
  beg_t        mb;
  int          n_checks = 0;
  int          n_fail = 0;
  int          wcount = 0;
  logic [31:0] mem [512];

  function automatic logic [31:0] buf_word(input int i);
    return 32'hC0DE0000 + 32'(i) * 32'h00010003;
  endfunction

  always @(posedge clock) begin
    if (pp_writeEnable) mem[pp_address] <= pp_dataIn;
    pp_dataOut <= mem[pp_address];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic extra(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s got=unexpected want=none", nm);
  endtask

  always @(negedge clock) begin
    if (n_reset) begin
      if (begin_transactionOUT) begin
        if (exp_beg.size() == 0) extra("begin");
        else begin
          mb = exp_beg.pop_front();
          chk("begin_addr", address_dataOUT, mb.a);
          chk("begin_bsize", 32'(busrt_sizeOUT), 32'(mb.bs));
          chk("begin_rnw", 32'(read_n_writeOUT), 32'(mb.rnw));
          chk("begin_be", 32'(byte_enableOUT), 32'(mb.be));
        end
      end
      if (data_validOUT && !busyIN) begin
        if (exp_w.size() == 0) extra("wdata");
        else chk("wdata", address_dataOUT, exp_w.pop_front());
        wcount++;
      end
      if (pp_writeEnable) begin
        if (exp_pa.size() == 0) extra("ppwrite");
        else begin
          chk("pp_addr", 32'(pp_address), 32'(exp_pa.pop_front()));
          chk("pp_data", pp_dataIn, exp_pd.pop_front());
        end
      end
    end
  end

  task automatic push_beg(input logic [31:0] a, input logic [7:0] bs,
                          input logic rnw, input logic [3:0] be);
    beg_t b;
    b.a = a; b.bs = bs; b.rnw = rnw; b.be = be;
    exp_beg.push_back(b);
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) exp_w.push_back(buf_word(i));
  endtask

  task automatic launch(input logic w, input logic r,
                        input logic [31:0] a, input logic [7:0] bs,
                        input logic [7:0] blk, input logic [3:0] be);
    @(posedge clock); #1;
    ipcore_launch_write = w; ipcore_launch_read = r;
    ipcore_address = a; ipcore_burst_size = bs;
    ipcore_block_sizeIN = blk; ipcore_byte_enable = be;
    @(posedge clock); #1;
    ipcore_launch_write = 0; ipcore_launch_read = 0;
  endtask

  task automatic wait_idle(input int lim);
    int k = 0;
    while (ipcore_dma_busy && k < lim) begin
      @(negedge clock); k++;
    end
    chk("idle_timeout", 32'(ipcore_dma_busy), 32'd0);
  endtask

  task automatic wait_words(input int n);
    int k = 0;
    while (wcount < n && k < 200) begin
      @(posedge clock); #1; k++;
    end
    chk("words_timeout", 32'(wcount >= n), 32'd1);
  endtask

  task automatic wait_begin(output bit ok);
    ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clock);
      if (begin_transactionOUT) ok = 1;
    end
    chk("begin_timeout", 32'(ok), 32'd1);
  endtask

  task automatic read_burst(input int n, inout int seq, input bit inj);
    bit ok;
    wait_begin(ok);
    if (ok) begin
      @(posedge clock); #1;
      for (int k = 0; k < n; k++) begin
        data_validIN = 1;
        address_dataIN = 32'hD0000000 + 32'(seq);
        ipcore_launch_write = inj && (k == 3);
        seq++;
        @(posedge clock); #1;
      end
      ipcore_launch_write = 0;
      data_validIN = 0; address_dataIN = 0;
      end_transactionIN = 1;
      @(posedge clock); #1;
      end_transactionIN = 0;
    end
  endtask

  initial begin
    int seq;
    for (int i = 0; i < 512; i++) mem[i] = buf_word(i);
    n_reset = 0;
    ipcore_launch_write = 0; ipcore_launch_read = 0;
    ipcore_byte_enable = 0; ipcore_address = 0;
    ipcore_burst_size = 0; ipcore_block_sizeIN = 0;
    address_dataIN = 0; end_transactionIN = 0; data_validIN = 0;
    busyIN = 0; bus_errorIN = 0; transactionGranted = 0;
    repeat (3) @(posedge clock);
    #1 n_reset = 1;
    @(negedge clock);
    chk("rst_busy", 32'(ipcore_dma_busy), 0);
    chk("rst_blk", 32'(ipcore_block_sizeOUT), 0);
    chk("rst_req", 32'(requestTransaction), 0);
    chk("rst_ppaddr", 32'(pp_address), 0);
    chk("rst_state", 32'(s_dma_cur_state), 0);

    // two-burst write with a late grant
    push_beg(32'hAABBCCDD, 8'd10, 0, 4'hF);
    push_beg(32'hAABBCD09, 8'd7, 0, 4'hF);
    push_words(19);
    launch(1, 0, 32'hAABBCCDD, 8'd10, 8'd19, 4'hF);
    @(negedge clock);
    chk("w1_busy", 32'(ipcore_dma_busy), 1);
    chk("w1_req", 32'(requestTransaction), 1);
    repeat (3) @(negedge clock);
    chk("w1_req_hold", 32'(requestTransaction), 1);
    @(posedge clock); #1 transactionGranted = 1;
    @(negedge clock);
    @(negedge clock);
    chk("w1_req_drop", 32'(requestTransaction), 0);
    wait_idle(300);
    chk("w1_blk", 32'(ipcore_block_sizeOUT), 19);

    // stall the bus for 10 cycles mid-burst
    wcount = 0;
    push_beg(32'h00000040, 8'd5, 0, 4'h5);
    push_words(6);
    launch(1, 0, 32'h40, 8'd7, 8'd6, 4'h5);
    wait_words(2);
    busyIN = 1;
    repeat (10) begin
      @(negedge clock);
      chk("frz_valid", 32'(data_validOUT), 1);
      chk("frz_data", address_dataOUT, buf_word(2));
    end
    @(posedge clock); #1 busyIN = 0;
    wait_idle(100);
    chk("busy_blk", 32'(ipcore_block_sizeOUT), 6);

    // bus error after five accepted words
    wcount = 0;
    push_beg(32'h00001000, 8'd100, 0, 4'hF);
    push_words(5);
    launch(1, 0, 32'h1000, 8'd100, 8'd200, 4'hF);
    wait_words(5);
    busyIN = 1; bus_errorIN = 1;
    @(posedge clock); #1 busyIN = 0; bus_errorIN = 0;
    @(negedge clock);
    chk("err_busy", 32'(ipcore_dma_busy), 0);
    chk("err_blk", 32'(ipcore_block_sizeOUT), 5);
    chk("err_valid", 32'(data_validOUT), 0);
    chk("err_end", 32'(end_transactionOUT), 0);

    // both launches together: write wins
    push_beg(32'h00000200, 8'd2, 0, 4'hF);
    push_words(3);
    launch(1, 1, 32'h200, 8'd7, 8'd3, 4'hF);
    wait_idle(100);
    chk("both_blk", 32'(ipcore_block_sizeOUT), 3);

    // zero-length block stays idle
    launch(1, 0, 32'h400, 8'd7, 8'd0, 4'hF);
    @(negedge clock);
    chk("zero_busy", 32'(ipcore_dma_busy), 0);
    chk("zero_req", 32'(requestTransaction), 0);

    // reset in the middle of a burst
    wcount = 0;
    push_beg(32'h00000300, 8'd9, 0, 4'hF);
    push_words(3);
    launch(1, 0, 32'h300, 8'd15, 8'd10, 4'hF);
    wait_words(3);
    n_reset = 0; busyIN = 1;
    @(posedge clock);
    @(negedge clock);
    chk("mrst_busy", 32'(ipcore_dma_busy), 0);
    chk("mrst_valid", 32'(data_validOUT), 0);
    chk("mrst_data", address_dataOUT, 0);
    chk("mrst_blk", 32'(ipcore_block_sizeOUT), 0);
    chk("mrst_ppaddr", 32'(pp_address), 0);
    @(posedge clock); #1 n_reset = 1; busyIN = 0;

    // read with an overrun word and an ignored launch
    push_beg(32'h00F00000, 8'd10, 1, 4'h3);
    push_beg(32'h00F0002C, 8'd8, 1, 4'h3);
    for (int i = 0; i < 20; i++) begin
      exp_pa.push_back(9'(i));
      exp_pd.push_back(32'hD0000000 + 32'(i));
    end
    launch(0, 1, 32'h00F00000, 8'd10, 8'd20, 4'h3);
    ipcore_address = 32'h5000; ipcore_block_sizeIN = 8'd4;
    seq = 0;
    read_burst(11, seq, 1);
    read_burst(10, seq, 0);
    wait_idle(100);
    chk("rd_blk", 32'(ipcore_block_sizeOUT), 20);
    chk("rd_mem19", mem[19], 32'hD0000013);
    repeat (5) @(negedge clock);
    chk("rd_stay_idle", 32'(ipcore_dma_busy), 0);

    chk("left_beg", 32'(exp_beg.size()), 0);
    chk("left_w", 32'(exp_w.size()), 0);
    chk("left_pp", 32'(exp_pa.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
